pc_next_unit: RTL and testbench

Parametrised program-counter unit for the MIPS core: it owns the PC register and selects the next PC. Sources are sequential, taken branch, J-type region jump and jump-register. It adds an optional one-instruction branch delay slot, stall hold, and misaligned jump-register trapping to an exception vector. It sits between the control unit/branch comparator and instruction memory.

---
 rtl/pc_next_unit.sv | 131 +++++++++++++
 tb/tb_pc_next_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Program-counter unit: owns the PC and picks the next one from sequential, branch, J-type and
// JR sources, with an optional one-instruction delay slot and misaligned-JR trapping.
module pc_next_unit #(
  parameter int unsigned    W          = 32,
  parameter logic [W-1:0]   RESET_VEC  = W'(32'h0000_0000),
  parameter logic [W-1:0]   EXC_VEC    = W'(32'h0000_0080),
  parameter bit             DELAY_SLOT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall_i,
  input  logic [1:0]   sel_i,
  input  logic [15:0]  imm_i,
  input  logic [25:0]  instr_idx_i,
  input  logic [W-1:0] rs_val_i,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pc_plus4_o,
  output logic [W-1:0] link_o,
  output logic         in_delay_slot_o,
  output logic         addr_err_o,
  output logic [W-1:0] epc_o,
  output logic         ds_violation_o
);

  typedef enum logic [0:0] {StIdle, StSlot} state_e;

  localparam logic [1:0] SelSeq = 2'b00;
  localparam logic [1:0] SelBr  = 2'b01;
  localparam logic [1:0] SelJ   = 2'b10;
  localparam logic [1:0] SelJr  = 2'b11;

  state_e       r_state, w_state_d;
  logic [W-1:0] r_pc, w_pc_d;
  logic [W-1:0] r_pend_tgt, w_pend_tgt_d;
  logic [W-1:0] r_epc, w_epc_d;
  logic         r_addr_err, w_addr_err_d;
  logic         r_ds_viol, w_ds_viol_d;

  logic [W-1:0] w_pc_plus4;
  logic [W-1:0] w_br_off;
  logic [W-1:0] w_br_tgt;
  logic [W-1:0] w_j_tgt;
  logic [W-1:0] w_target;
  logic         w_misaligned;

  assign w_pc_plus4 = r_pc + W'(4);
  assign w_br_off   = {{(W-18){imm_i[15]}}, imm_i, 2'b00};
  assign w_br_tgt   = w_pc_plus4 + w_br_off;

  // J-type keeps the 256 MB region of the following instruction.
  if (W > 28) begin : g_jwide
    assign w_j_tgt = {w_pc_plus4[W-1:28], instr_idx_i, 2'b00};
  end else begin : g_jnarrow
    assign w_j_tgt = {instr_idx_i, 2'b00};
  end

  always_comb begin
    w_target = w_pc_plus4;
    unique case (sel_i)
      SelSeq:  w_target = w_pc_plus4;
      SelBr:   w_target = w_br_tgt;
      SelJ:    w_target = w_j_tgt;
      SelJr:   w_target = rs_val_i;
      default: w_target = w_pc_plus4;
    endcase
  end

  assign w_misaligned = (sel_i == SelJr) && (rs_val_i[1:0] != 2'b00);

  always_comb begin
    w_state_d     = r_state;
    w_pc_d        = r_pc;
    w_pend_tgt_d  = r_pend_tgt;
    w_epc_d       = r_epc;
    w_addr_err_d  = 1'b0;
    w_ds_viol_d   = 1'b0;
    if (!stall_i) begin
      unique case (r_state)
        StIdle: begin
          if (sel_i == SelSeq) begin
            w_pc_d = w_pc_plus4;
          end else if (w_misaligned) begin
            w_pc_d       = EXC_VEC;
            w_epc_d      = r_pc;
            w_addr_err_d = 1'b1;
          end else if (DELAY_SLOT) begin
            w_pend_tgt_d = w_target;
            w_pc_d       = w_pc_plus4;
            w_state_d    = StSlot;
          end else begin
            w_pc_d = w_target;
          end
        end
        StSlot: begin
          // A transfer issued from the slot is dropped, never trapped.
          w_pc_d      = r_pend_tgt;
          w_state_d   = StIdle;
          w_ds_viol_d = (sel_i != SelSeq);
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_pc       <= RESET_VEC;
      r_pend_tgt <= '0;
      r_epc      <= '0;
      r_addr_err <= 1'b0;
      r_ds_viol  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_pend_tgt <= w_pend_tgt_d;
      r_epc      <= w_epc_d;
      r_addr_err <= w_addr_err_d;
      r_ds_viol  <= w_ds_viol_d;
    end
  end

  assign pc_o            = r_pc;
  assign pc_plus4_o      = w_pc_plus4;
  assign link_o          = DELAY_SLOT ? (r_pc + W'(8)) : w_pc_plus4;
  assign in_delay_slot_o = (r_state == StSlot);
  assign addr_err_o      = r_addr_err;
  assign epc_o           = r_epc;
  assign ds_violation_o  = r_ds_viol;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: three instances (W32 no slot, W32 slot, W40 no slot),
// directed vectors push hand-computed expectations, a monitor pops and compares after each edge.
module tb_pc_next_unit;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        rstn   [3];
  logic        stall  [3];
  logic [1:0]  sel    [3];
  logic [15:0] imm    [3];
  logic [25:0] idx    [3];
  logic [63:0] rs     [3];

  logic [31:0] pc0, p40, lk0, epc0, pc1, p41, lk1, epc1;
  logic [39:0] pc2, p42, lk2, epc2;
  logic        ids0, ae0, dv0, ids1, ae1, dv1, ids2, ae2, dv2;

  pc_next_unit #(.W(32), .DELAY_SLOT(1'b0)) u_d0 (
    .clk(clk), .rst_n(rstn[0]), .stall_i(stall[0]), .sel_i(sel[0]), .imm_i(imm[0]),
    .instr_idx_i(idx[0]), .rs_val_i(rs[0][31:0]), .pc_o(pc0), .pc_plus4_o(p40), .link_o(lk0),
    .in_delay_slot_o(ids0), .addr_err_o(ae0), .epc_o(epc0), .ds_violation_o(dv0)
  );

  pc_next_unit #(.W(32), .DELAY_SLOT(1'b1)) u_d1 (
    .clk(clk), .rst_n(rstn[1]), .stall_i(stall[1]), .sel_i(sel[1]), .imm_i(imm[1]),
    .instr_idx_i(idx[1]), .rs_val_i(rs[1][31:0]), .pc_o(pc1), .pc_plus4_o(p41), .link_o(lk1),
    .in_delay_slot_o(ids1), .addr_err_o(ae1), .epc_o(epc1), .ds_violation_o(dv1)
  );

  pc_next_unit #(.W(40), .DELAY_SLOT(1'b0)) u_d2 (
    .clk(clk), .rst_n(rstn[2]), .stall_i(stall[2]), .sel_i(sel[2]), .imm_i(imm[2]),
    .instr_idx_i(idx[2]), .rs_val_i(rs[2][39:0]), .pc_o(pc2), .pc_plus4_o(p42), .link_o(lk2),
    .in_delay_slot_o(ids2), .addr_err_o(ae2), .epc_o(epc2), .ds_violation_o(dv2)
  );

  typedef struct {
    int          id;
    logic [63:0] pc;
    logic        ids;
    logic        ae;
    logic [63:0] epc;
    logic        dv;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Drive one DUT for one edge; the others are held by stall.
  task automatic step(input int id, input logic rn, input logic st, input logic [1:0] s,
                      input logic [15:0] im, input logic [25:0] ix, input logic [63:0] r,
                      input logic [63:0] e_pc, input logic e_ids, input logic e_ae,
                      input logic [63:0] e_epc, input logic e_dv, input string nm);
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rstn[k]  = 1'b1;
      stall[k] = 1'b1;
      sel[k]   = 2'b00;
    end
    rstn[id]  = rn;
    stall[id] = st;
    sel[id]   = s;
    imm[id]   = im;
    idx[id]   = ix;
    rs[id]    = r;
    e.id = id; e.pc = e_pc; e.ids = e_ids; e.ae = e_ae; e.epc = e_epc; e.dv = e_dv; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [63:0] a_pc, a_p4, a_lk, a_epc, mask, x_p4, x_lk;
    logic        a_ids, a_ae, a_dv;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        unique case (e.id)
          0: begin
            a_pc = 64'(pc0); a_p4 = 64'(p40); a_lk = 64'(lk0); a_epc = 64'(epc0);
            a_ids = ids0; a_ae = ae0; a_dv = dv0;
          end
          1: begin
            a_pc = 64'(pc1); a_p4 = 64'(p41); a_lk = 64'(lk1); a_epc = 64'(epc1);
            a_ids = ids1; a_ae = ae1; a_dv = dv1;
          end
          default: begin
            a_pc = 64'(pc2); a_p4 = 64'(p42); a_lk = 64'(lk2); a_epc = 64'(epc2);
            a_ids = ids2; a_ae = ae2; a_dv = dv2;
          end
        endcase
        mask = (e.id == 2) ? 64'hFF_FFFF_FFFF : 64'hFFFF_FFFF;
        x_p4 = (e.pc + 64'd4) & mask;
        x_lk = (e.pc + ((e.id == 1) ? 64'd8 : 64'd4)) & mask;
        total++;
        if (a_pc !== e.pc || a_p4 !== x_p4 || a_lk !== x_lk || a_ids !== e.ids ||
            a_ae !== e.ae || a_epc !== e.epc || a_dv !== e.dv) begin
          bad++;
          $display("FAIL %s: got pc=%h p4=%h link=%h ds=%b ae=%b epc=%h dv=%b | want pc=%h p4=%h link=%h ds=%b ae=%b epc=%h dv=%b",
                   e.nm, a_pc, a_p4, a_lk, a_ids, a_ae, a_epc, a_dv,
                   e.pc, x_p4, x_lk, e.ids, e.ae, e.epc, e.dv);
        end
      end
    end
  end

  initial begin : stim
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b1; stall[k] = 1'b1; sel[k] = '0; imm[k] = '0; idx[k] = '0; rs[k] = '0;
    end

    // W32, immediate redirect
    step(0, 0, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, "d0 reset a");
    step(0, 0, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, "d0 reset b");
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h4, 0, 0, 64'h0, 0, "d0 seq 1");
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h8, 0, 0, 64'h0, 0, "d0 seq 2");
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'hC, 0, 0, 64'h0, 0, "d0 seq 3");
    step(0, 1, 0, 2'b11, 16'h0, 26'h0, 64'h100, 64'h100, 0, 0, 64'h0, 0, "d0 jr 100");
    step(0, 1, 0, 2'b01, 16'hFFFC, 26'h0, 64'h0, 64'hF4, 0, 0, 64'h0, 0, "d0 br back");
    step(0, 1, 0, 2'b11, 16'h0, 26'h0, 64'h9000_0010, 64'h9000_0010, 0, 0, 64'h0, 0, "d0 jr hi");
    step(0, 1, 0, 2'b10, 16'h0, 26'h40, 64'h0, 64'h9000_0100, 0, 0, 64'h0, 0, "d0 jump");
    step(0, 1, 0, 2'b11, 16'h0, 26'h0, 64'h40, 64'h40, 0, 0, 64'h0, 0, "d0 jr 40");
    step(0, 1, 0, 2'b11, 16'h0, 26'h0, 64'h1002, 64'h80, 0, 1, 64'h40, 0, "d0 jr trap");
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h84, 0, 0, 64'h40, 0, "d0 trap pulse end");
    step(0, 1, 0, 2'b11, 16'h0, 26'h0, 64'h1000, 64'h1000, 0, 0, 64'h40, 0, "d0 jr aligned");
    step(0, 1, 1, 2'b01, 16'h5, 26'h0, 64'h0, 64'h1000, 0, 0, 64'h40, 0, "d0 stall hold");
    step(0, 1, 0, 2'b11, 16'h0, 26'h0, 64'hFFFF_FFFC, 64'hFFFF_FFFC, 0, 0, 64'h40, 0, "d0 jr top");
    step(0, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h0, 0, 0, 64'h40, 0, "d0 wrap");
    step(0, 1, 0, 2'b11, 16'h0, 26'h0, 64'h3, 64'h80, 0, 1, 64'h0, 0, "d0 trap at 0");
    step(0, 1, 1, 2'b11, 16'h0, 26'h0, 64'h3, 64'h80, 0, 0, 64'h0, 0, "d0 stall after trap");

    // W32, delay slot
    step(1, 0, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, "d1 reset a");
    step(1, 0, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, "d1 reset b");
    step(1, 1, 0, 2'b11, 16'h0, 26'h0, 64'h20, 64'h4, 1, 0, 64'h0, 0, "d1 jr 20 slot");
    step(1, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h20, 0, 0, 64'h0, 0, "d1 jr 20 done");
    step(1, 1, 0, 2'b01, 16'h8, 26'h0, 64'h0, 64'h24, 1, 0, 64'h0, 0, "d1 br slot");
    step(1, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h44, 0, 0, 64'h0, 0, "d1 br done");
    step(1, 1, 0, 2'b01, 16'hFFF6, 26'h0, 64'h0, 64'h48, 1, 0, 64'h0, 0, "d1 br back slot");
    step(1, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h20, 0, 0, 64'h0, 0, "d1 br back done");
    step(1, 1, 0, 2'b01, 16'h8, 26'h0, 64'h0, 64'h24, 1, 0, 64'h0, 0, "d1 br slot 2");
    step(1, 1, 0, 2'b10, 16'h0, 26'h3FF, 64'h0, 64'h44, 0, 0, 64'h0, 1, "d1 jump in slot");
    step(1, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h48, 0, 0, 64'h0, 0, "d1 viol pulse end");
    step(1, 1, 0, 2'b01, 16'hFFFD, 26'h0, 64'h0, 64'h4C, 1, 0, 64'h0, 0, "d1 br to 40 slot");
    step(1, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h40, 0, 0, 64'h0, 0, "d1 br to 40 done");
    step(1, 1, 0, 2'b11, 16'h0, 26'h0, 64'h1002, 64'h80, 0, 1, 64'h40, 0, "d1 jr trap");
    step(1, 1, 0, 2'b01, 16'hFFEF, 26'h0, 64'h0, 64'h84, 1, 0, 64'h40, 0, "d1 br to 40 slot b");
    step(1, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h40, 0, 0, 64'h40, 0, "d1 br to 40 done b");
    step(1, 1, 0, 2'b11, 16'h0, 26'h0, 64'h1000, 64'h44, 1, 0, 64'h40, 0, "d1 jr slot");
    for (int k = 0; k < 3; k++)
      step(1, 1, 1, 2'b11, 16'h0, 26'h0, 64'h3, 64'h44, 1, 0, 64'h40, 0, "d1 stall in slot");
    step(1, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h1000, 0, 0, 64'h40, 0, "d1 jr done");
    step(1, 1, 0, 2'b01, 16'h1, 26'h0, 64'h0, 64'h1004, 1, 0, 64'h40, 0, "d1 br pending");
    step(1, 0, 1, 2'b00, 16'h0, 26'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, "d1 reset over stall");
    step(1, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h4, 0, 0, 64'h0, 0, "d1 seq after reset");
    step(1, 1, 0, 2'b11, 16'h0, 26'h0, 64'h8, 64'h8, 1, 0, 64'h0, 0, "d1 jr 8 slot");
    step(1, 1, 0, 2'b11, 16'h0, 26'h0, 64'h2, 64'h8, 0, 0, 64'h0, 1, "d1 bad jr in slot");
    step(1, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'hC, 0, 0, 64'h0, 0, "d1 seq after viol");

    // W40, immediate redirect
    step(2, 0, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, "d2 reset");
    step(2, 1, 0, 2'b01, 16'h7FFF, 26'h0, 64'h0, 64'h2_0000, 0, 0, 64'h0, 0, "d2 br fwd max");
    step(2, 1, 0, 2'b11, 16'h0, 26'h0, 64'hAB_C000_0010, 64'hAB_C000_0010, 0, 0, 64'h0, 0,
         "d2 jr hi");
    step(2, 1, 0, 2'b10, 16'h0, 26'h40, 64'h0, 64'hAB_C000_0100, 0, 0, 64'h0, 0, "d2 jump");
    step(2, 1, 0, 2'b11, 16'h0, 26'h0, 64'hFF_FFFF_FFFC, 64'hFF_FFFF_FFFC, 0, 0, 64'h0, 0,
         "d2 jr top");
    step(2, 1, 0, 2'b00, 16'h0, 26'h0, 64'h0, 64'h0, 0, 0, 64'h0, 0, "d2 wrap");
    step(2, 1, 0, 2'b11, 16'h0, 26'h0, 64'h1, 64'h80, 0, 1, 64'h0, 0, "d2 jr trap");

    begin : drain
      int n;
      n = 0;
      while (q.size() != 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) begin
        total++;
        bad++;
        $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
